// File: rtl/boom_trace_pkg.sv
// boom_trace_pkg: trace-buffer geometry shared by the trace writer and the drain engine
package boom_trace_pkg;
  localparam logic [31:0] BOOM_TRACE_BASEADDR = 32'h0010_0000;
  localparam int BOOM_TRACE_SIZE = 'h8000;
  localparam int BOOM_MEM_DATA_SIZE = 128;
  localparam int BOOM_MEM_ADDR_SIZE = 32;
  localparam int TRACEMEM_DATAWIDTH = 173;
  localparam int ROW_BYTES = 32;
  localparam int ROW_LOG2 = 5;
  localparam int ROWS = BOOM_TRACE_SIZE >> ROW_LOG2;
  localparam int AW = $clog2(ROWS);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} drain_state_e;
endpackage

// File: rtl/boom_trace_drain_fifo.sv
// boom_trace_drain_fifo: 2-entry beat buffer (data plus last flag) with synchronous clear
module boom_trace_drain_fifo
  import boom_trace_pkg::*;
#(
  parameter int W = BOOM_MEM_DATA_SIZE + 1
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         valid,
  output logic [1:0]   level
);
  logic [W-1:0] mem [2];
  logic wp, rp;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      wp <= 1'b0;
      rp <= 1'b0;
      level <= 2'd0;
    end else if (clear) begin
      wp <= 1'b0;
      rp <= 1'b0;
      level <= 2'd0;
    end else begin
      wp <= wp ^ push;
      rp <= rp ^ pop;
      level <= level + 2'(push) - 2'(pop);
    end
  always_ff @(posedge clk_i)
    if (push && !clear) mem[wp] <= wdata;
  // Empty head reads as zero so the stream outputs are clean out of reset
  assign valid = level != 2'd0;
  assign rdata = valid ? mem[rp] : '0;
endmodule

// File: rtl/boom_trace_drain.sv
// boom_trace_drain: reads every valid trace row oldest-first and streams each row as two 128-bit beats
module boom_trace_drain
  import boom_trace_pkg::*;
(
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          start_i,
  input  logic                          abort_i,
  input  logic [BOOM_MEM_ADDR_SIZE-1:0] trace_ptr_i,
  input  logic [BOOM_MEM_ADDR_SIZE-1:0] trace_count_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [AW:0]                   rows_sent_o,
  output logic                          mem_en_o,
  output logic [BOOM_MEM_ADDR_SIZE-1:0] mem_addr_o,
  input  logic [BOOM_MEM_DATA_SIZE-1:0] mem_rdata_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [BOOM_MEM_DATA_SIZE-1:0] out_data_o,
  output logic                          out_last_o
);
  drain_state_e state, state_nxt;
  logic [AW-1:0] row;
  logic [AW+1:0] reads_left;
  logic [AW:0] n;
  logic [1:0] level;
  logic half, inflight, inflight_last, beat_half, issue, fire, unused_ok;
  assign unused_ok = &{1'b0, trace_ptr_i[BOOM_MEM_ADDR_SIZE-1:AW]};
  assign n = trace_count_i > 32'(ROWS) ? (AW+1)'(ROWS) : trace_count_i[AW:0];
  assign fire = out_valid_o && out_ready_i;
  // A beat leaving this cycle frees its slot, keeping full throughput with at most two reads held
  assign issue = state == RUN && !abort_i && (level + {1'b0, inflight} - {1'b0, fire}) < 2'd2;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = start_i ? (n == '0 ? DONE : RUN) : IDLE;
      RUN: state_nxt = issue && reads_left == (AW+2)'(1) ? FLUSH : RUN;
      FLUSH: state_nxt = !inflight && level == {1'b0, fire} ? DONE : FLUSH;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort_i) state_nxt = IDLE;
  end
  always_comb begin
    busy_o = state == RUN || state == FLUSH;
    done_o = state == DONE;
    mem_en_o = issue;
    mem_addr_o = BOOM_TRACE_BASEADDR + 32'({row, half, 4'b0000});
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      row <= '0;
      half <= 1'b0;
      reads_left <= '0;
      inflight <= 1'b0;
      inflight_last <= 1'b0;
      beat_half <= 1'b0;
      rows_sent_o <= '0;
    end else begin
      inflight <= issue;
      inflight_last <= issue && reads_left == (AW+2)'(1);
      if (state == IDLE && start_i && !abort_i) begin
        row <= trace_ptr_i[AW-1:0] - n[AW-1:0];
        half <= 1'b0;
        reads_left <= {n, 1'b0};
        beat_half <= 1'b0;
        rows_sent_o <= '0;
      end else begin
        if (issue) begin
          row <= row + AW'(half);
          half <= ~half;
          reads_left <= reads_left - (AW+2)'(1);
        end
        if (fire) begin
          beat_half <= ~beat_half;
          rows_sent_o <= rows_sent_o + (AW+1)'(beat_half);
        end
      end
    end
  boom_trace_drain_fifo u_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear  (abort_i),
    .push   (inflight),
    .pop    (fire),
    .wdata  ({inflight_last, mem_rdata_i}),
    .rdata  ({out_last_o, out_data_o}),
    .valid  (out_valid_o),
    .level  (level)
  );
endmodule

// File: tb/tb_boom_trace_drain.sv
// tb_boom_trace_drain: directed and randomized drains checked against a row-order memory model
module tb_boom_trace_drain;
  import boom_trace_pkg::*;
  logic clk_i = 1'b0, reset_i = 1'b1, start_i = 1'b0, abort_i = 1'b0, out_ready_i = 1'b0;
  logic [31:0] trace_ptr_i = '0, trace_count_i = '0;
  logic busy_o, done_o, mem_en_o, out_valid_o, out_last_o;
  logic [AW:0] rows_sent_o;
  logic [31:0] mem_addr_o;
  logic [127:0] mem_rdata_i = '0, out_data_o;
  int checks = 0, errors = 0, cyc = 0, issued = 0, taken = 0;
  int done_cnt = 0, done_cyc = 0, first_hs = 0, last_hs = 0;
  bit hold = 1'b0;
  logic [128:0] held;
  logic [127:0] memw [2048];
  logic [31:0] addr_q [$];
  logic [128:0] beat_q [$];

  boom_trace_drain dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .abort_i(abort_i),
    .trace_ptr_i(trace_ptr_i), .trace_count_i(trace_count_i),
    .busy_o(busy_o), .done_o(done_o), .rows_sent_o(rows_sent_o),
    .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_last_o(out_last_o)
  );

  always #5 clk_i = ~clk_i;

  // Trace memory: 16-byte words, data returned the cycle after the read enable
  always @(posedge clk_i) begin
    cyc++;
    if (mem_en_o) mem_rdata_i <= memw[11'((mem_addr_o - BOOM_TRACE_BASEADDR) >> 4)];
  end

  task automatic chk(input string tag, input logic [129:0] obs, input logic [129:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_i) begin
    logic [31:0] ea;
    logic [128:0] eb;
    if (reset_i) hold = 1'b0;
    else begin
      if (mem_en_o) begin
        ea = 'x;
        if (addr_q.size() != 0) ea = addr_q.pop_front();
        chk("mem_addr", 130'(mem_addr_o), 130'(ea));
        issued++;
      end
      if (hold) chk("stall_stable", 130'({out_valid_o, out_last_o, out_data_o}), 130'({1'b1, held}));
      if (out_valid_o && out_ready_i) begin
        eb = 'x;
        if (beat_q.size() != 0) eb = beat_q.pop_front();
        chk("beat", 130'({out_last_o, out_data_o}), 130'(eb));
        taken++;
        if (taken == 1) first_hs = cyc;
        last_hs = cyc;
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      chk("outstanding", 130'(issued - taken <= 2), 130'(1));
      hold = out_valid_o && !out_ready_i && !abort_i;
      held = {out_last_o, out_data_o};
    end
  end

  task automatic drain(input int ptr, input int cnt, input bit rnd, input int abort_at, input int rst_at);
    int n, s, r;
    bit stop;
    stop = 1'b0;
    n = cnt > 1024 ? 1024 : cnt;
    addr_q.delete();
    beat_q.delete();
    issued = 0;
    taken = 0;
    done_cnt = 0;
    for (int i = 0; i < n; i++) begin
      r = ((ptr % 1024) - n + i + 2048) % 1024;
      for (int h = 0; h < 2; h++) begin
        addr_q.push_back(BOOM_TRACE_BASEADDR + 32'(r * 32 + h * 16));
        beat_q.push_back({i == n - 1 && h == 1, memw[r * 2 + h]});
      end
    end
    @(posedge clk_i); #1;
    trace_ptr_i = 32'(ptr);
    trace_count_i = 32'(cnt);
    start_i = 1'b1;
    out_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    s = cyc + 1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    trace_ptr_i = $urandom;
    trace_count_i = $urandom;
    out_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk_i);
    chk("busy_cycle1", 130'(busy_o), 130'(n != 0));
    chk("mem_en_cycle1", 130'(mem_en_o), 130'(n != 0));
    chk("done_cycle1", 130'(done_o), 130'(n == 0));
    for (int k = 0; k < 6000 && !stop; k++) begin
      @(posedge clk_i); #1;
      if (done_cnt != 0) stop = 1'b1;
      else if (abort_at >= 0 && taken == abort_at) begin
        out_ready_i = 1'b0;
        abort_i = 1'b1;
        @(posedge clk_i); #1;
        abort_i = 1'b0;
        @(negedge clk_i);
        chk("abort_valid", 130'(out_valid_o), 130'(0));
        chk("abort_busy", 130'(busy_o), 130'(0));
        chk("abort_rows", 130'(rows_sent_o), 130'(abort_at / 2));
        repeat (3) @(negedge clk_i);
        chk("abort_no_done", 130'(done_cnt), 130'(0));
        return;
      end else if (rst_at >= 0 && taken == rst_at) begin
        reset_i = 1'b1;
        #1;
        chk("rst_busy", 130'(busy_o), 130'(0));
        chk("rst_valid", 130'(out_valid_o), 130'(0));
        chk("rst_addr", 130'(mem_addr_o), 130'(BOOM_TRACE_BASEADDR));
        chk("rst_rows", 130'(rows_sent_o), 130'(0));
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        return;
      end else out_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    chk("done_seen", 130'(stop), 130'(1));
    chk("done_once", 130'(done_cnt), 130'(1));
    chk("rows_sent", 130'(rows_sent_o), 130'(n));
    chk("beat_count", 130'(taken), 130'(2 * n));
    chk("model_drained", 130'(beat_q.size() + addr_q.size()), 130'(0));
    chk("busy_after", 130'(busy_o), 130'(0));
    chk("done_cycle", 130'(done_cyc), 130'(n == 0 ? s : last_hs + 1));
    if (!rnd && n != 0) begin
      chk("first_beat_cycle", 130'(first_hs), 130'(s + 2));
      chk("back_to_back", 130'(last_hs - first_hs), 130'(2 * n - 1));
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++)
      memw[i] = (i % 2 == 1) ? 128'({$urandom, $urandom} & 64'h1FFF_FFFF_FFFF)
                             : {$urandom, $urandom, $urandom, $urandom};
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_outputs", 130'({busy_o, done_o, rows_sent_o, mem_en_o, out_valid_o, out_last_o}), 130'(0));
    chk("reset_addr", 130'(mem_addr_o), 130'(BOOM_TRACE_BASEADDR));
    chk("reset_data", 130'(out_data_o), 130'(0));
    reset_i = 1'b0;
    @(negedge clk_i);
    chk("idle_busy", 130'(busy_o), 130'(0));
    drain(0, 0, 1'b0, -1, -1);
    drain(5, 3, 1'b0, -1, -1);
    drain(2, 4, 1'b0, -1, -1);
    repeat (6) drain(int'($urandom_range(0, 1023)), int'($urandom_range(1, 40)), 1'b1, -1, -1);
    drain(1000, 50, 1'b1, -1, -1);
    drain(0, 'h7FF, 1'b0, -1, -1);
    drain(700, 4, 1'b0, 3, -1);
    drain(1, 1, 1'b0, -1, -1);
    drain(300, 4, 1'b0, -1, 3);
    drain(1, 1, 1'b0, -1, -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
